// File: rtl/uart_pkg.sv
// Shared types and register-layout constants for the UART FIFO controller.
package uart_pkg;

    // TX handshake sequencer states
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ACK  = 2'd1,
        TX_WAIT = 2'd2
    } TX_STATE_E;

    // Bit positions inside the read word returned to the bus interface
    localparam int RX_DATA_LSB = 0;
    localparam int RX_OVR_BIT  = 8;
    localparam int TX_DROP_BIT = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head. It executes push/pop exactly as
// asked; callers gate push with full and pop with empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next pointers, count and storage; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge ACLK) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART datapath sequencer: TX/RX byte FIFOs behind the AXI4-lite slave,
// start/busy handshake towards the transmitter, sticky error flags and irq.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              wr_amba,
    input  logic [31:0]       data_out,
    input  logic [3:0]        strb,
    input  logic              rd_amba,
    output logic [31:0]       data_in,
    output logic              full,
    output logic              empty,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              irq
);
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;

    logic              tx_drop_set, rx_ovr_set;
    logic              tx_drop_q, tx_drop_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              irq_q, irq_d;

    TX_STATE_E         state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    // Push/pop gating: a full FIFO rejects pushes even with a concurrent pop
    always_comb begin
        tx_push     = wr_amba & strb[0] & ~tx_full;
        tx_drop_set = wr_amba & strb[0] &  tx_full;
        rx_push     = rx_valid & ~rx_full;
        rx_ovr_set  = rx_valid &  rx_full;
        rx_pop      = rd_amba  & ~rx_empty;
        tx_pop      = (state_q == TX_IDLE) & ~tx_empty & ~tx_busy;
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (data_out[DATA_W-1:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky flags (set beats clear) and irq computed from current state
    always_comb begin
        tx_drop_d    = tx_drop_set ? 1'b1 : (rd_amba ? 1'b0 : tx_drop_q);
        rx_overrun_d = rx_ovr_set  ? 1'b1 : (rd_amba ? 1'b0 : rx_overrun_q);
        irq_d        = ~rx_empty | rx_overrun_q | tx_drop_q;
    end

    // Flag and irq registers
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            tx_drop_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            tx_drop_q    <= tx_drop_d;
            rx_overrun_q <= rx_overrun_d;
            irq_q        <= irq_d;
        end
    end

    // TX handshake next-state: launch from IDLE, wait for busy rise then fall
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            TX_IDLE: if (tx_pop) begin
                tx_start_d = 1'b1;
                tx_data_d  = tx_head;
                state_d    = TX_ACK;
            end
            TX_ACK:  if (tx_busy)  state_d = TX_WAIT;
            TX_WAIT: if (!tx_busy) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // TX FSM state and its registered outputs
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q    <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Read word: head byte (zero when empty) plus the sticky flags
    always_comb begin
        data_in = '0;
        if (!rx_empty) data_in[RX_DATA_LSB +: 8] = 8'(rx_head);
        data_in[RX_OVR_BIT]  = rx_overrun_q;
        data_in[TX_DROP_BIT] = tx_drop_q;
    end

    assign full     = tx_full;
    assign empty    = rx_empty;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign irq      = irq_q;

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Sequences the UART datapath behind the AXI4-lite slave interface.
- Buffers bytes written over AXI into a TX FIFO and hands them one at a time to the UART transmitter through a start/busy handshake.
- Buffers bytes received by the UART into an RX FIFO, which AXI reads drain.
- Generates the `full`/`empty` flags and the read data word consumed by the bus interface.

Parameters:
- DATA_W, 8: UART character width in bits.
- TX_DEPTH, 16: TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 16: RX FIFO entries; power of two, minimum 2.

Ports:
- ACLK  input  1  system clock, rising edge.
- ARST  input  1  synchronous reset, active-high.
- wr_amba  input  1  one-cycle write strobe from the bus interface.
- data_out  input  32  write data from the bus interface; bits [DATA_W-1:0] are used.
- strb  input  4  write byte strobes; push only when strb[0]=1.
- rd_amba  input  1  one-cycle read-complete strobe (R handshake on the RX address); pops RX.
- data_in  output  32  read word: {22'b0, tx_drop, rx_overrun, rx_head[7:0]}.
- full  output  1  TX FIFO full, combinational from count.
- empty  output  1  RX FIFO empty, combinational from count.
- tx_start  output  1  one-cycle start pulse to the UART TX.
- tx_data  output  DATA_W  byte for the UART TX; held from the tx_start cycle until the next start.
- tx_busy  input  1  UART TX shifting.
- rx_valid  input  1  one-cycle pulse, received byte available.
- rx_data  input  DATA_W  received byte.
- irq  output  1  registered; high while RX is non-empty or either sticky flag is set.

Behaviour:
- Reset values: both FIFOs empty (pointers and counts 0), `full`=0, `empty`=1, `tx_start`=0, `tx_data`=0, `rx_overrun`=0, `tx_drop`=0, `irq`=0, TX FSM in TX_IDLE.
- Reset mid-operation aborts any handshake. Queued bytes are discarded. `tx_start` is low in the cycle after ARST is sampled.
- TX push:
  - Occurs when wr_amba=1, strb[0]=1 and `full`=0; takes effect at that clock edge.
  - wr_amba=1 while `full`=1 drops the byte and sets sticky `tx_drop`.
  - strb[0]=0 is a no-op.
- TX FSM, three states:
  - TX_IDLE: if TX not empty and tx_busy=0, register tx_start=1 and tx_data=head, pop TX, go to TX_ACK.
  - TX_ACK: tx_start=0; wait for tx_busy=1, then go to TX_WAIT.
  - TX_WAIT: wait for tx_busy=0, then go to TX_IDLE.
- TX latency: wr_amba in cycle N gives tx_start high in cycle N+2 when the FSM is idle and tx_busy=0.
- Back-to-back bytes are separated by at least 2 cycles after busy falls.
- RX push: rx_valid=1 pushes rx_data. If RX is full, the byte is dropped and sticky `rx_overrun` is set; stored data is unchanged.
- RX pop: rd_amba=1 with RX non-empty advances the head. rd_amba while empty does not move pointers.
- Flag clearing: any rd_amba clears both `rx_overrun` and `tx_drop`.
  - Set and clear in the same cycle: set wins.
- data_in: combinational from the current head, `rx_overrun` and `tx_drop`. rx_head reads 0 when empty.
- Simultaneous push and pop on the same FIFO:
  - Not full and not empty: both happen, count unchanged.
  - Full: the push is rejected even with a concurrent pop, so `full` depends only on the pre-edge count.
  - Empty: the pop is ignored and the push happens.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits and saturates neither way.
- `irq` is registered one cycle after its sources change.

Decomposition:
- Shared package uart_pkg holds:
  - the TX_STATE_E enum (TX_IDLE, TX_ACK, TX_WAIT);
  - localparams for data_in bit positions (RX_DATA_LSB=0, RX_OVR_BIT=8, TX_DROP_BIT=9).
- One sub-module, sync_fifo:
  - parameters WIDTH and DEPTH; ports push, pop, wdata, rdata (head), full, empty, count;
  - same ACLK/ARST;
  - instantiated twice (TX, RX).
- The overflow/drop policy lives in uart_fifo_ctrl, not in sync_fifo.

Test Plan:
- Reset, then write 0x41 with strb=4'b0001 and tx_busy tied low for now → tx_start pulses once exactly 2 cycles after wr_amba with tx_data=0x41; `full` stays 0; TX empties.
- Write 16 bytes 0x00..0x0F with tx_busy held high → `full`=1 after the 16th; a 17th write sets `tx_drop`; release busy with a 4-cycle busy model per byte → bytes emitted in order 0x00..0x0F, none lost.
- Inject 3 rx_valid bytes 0xA1, 0xA2, 0xA3 → `empty`=0, `irq`=1 one cycle later; three rd_amba pulses → data_in[7:0] reads A1, A2, A3; `empty`=1, `irq`=0 afterwards.
- Inject 17 RX bytes with no reads → `rx_overrun`=1 and data_in[8]=1; 16 reads return the first 16 bytes; the first rd_amba clears the flag.
- RX full with rx_valid and rd_amba in the same cycle → push rejected, pop done, count 15, overrun set; empty with both pulses → count 1, head = new byte.
- Assert ARST while in TX_WAIT with 5 bytes queued → `tx_start` low, `full`=0, `empty`=1, flags 0 the next cycle; a following write transmits normally.
